// File: rtl/fir_delay_line_pkg.sv
// -----------------------------------------------------------------------------
// fir_delay_line_pkg
// Constants and the handshake state type shared by the FIR delay line and the
// MAC stage that consumes its taps.
//   FIR_DATA_WIDTH : sample / tap width in bits
//   FIR_NUM_REGS   : number of taps (must be >= 2)
//   fir_state_e    : delay-line state (StFill, StRun, StHold)
// -----------------------------------------------------------------------------
package fir_delay_line_pkg;

    localparam int unsigned FIR_DATA_WIDTH = 16;
    localparam int unsigned FIR_NUM_REGS   = 4;

    // StFill : fewer than NUM_REGS samples held
    // StRun  : full, no vector pending
    // StHold : full, vector pending until the MAC stage takes it
    typedef enum logic [1:0] {
        StFill = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } fir_state_e;

endpackage

// File: rtl/fir_delay_line.sv
// -----------------------------------------------------------------------------
// fir_delay_line
// Tap delay line for the FIR accelerator. Each accepted sample shifts into a
// NUM_REGS-deep register chain whose taps are presented in parallel to the MAC
// stage, with valid/ready so every tap vector is consumed exactly once.
//
// Build option:
//   FIR_ZERO_PAD_EN defined   : a vector is issued after every accept, the
//                               not-yet-filled taps read as zero.
//   FIR_ZERO_PAD_EN undefined : no vector until NUM_REGS samples have been
//                               accepted since reset or flush.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rstN         in   asynchronous active-low reset
//   sampleIn     in   raw sensor sample
//   sampleValid  in   sampleIn is valid
//   sampleReady  out  a sample can be accepted this cycle (combinational)
//   flush        in   synchronous clear of taps, fill count and pending vector
//   pDataOut     out  parallel taps, index 0 newest
//   pDataValid   out  pDataOut holds an unconsumed vector
//   pDataReady   in   MAC stage consumes pDataOut this cycle
//   fillCount    out  samples held, saturating at NUM_REGS
// -----------------------------------------------------------------------------
module fir_delay_line
    import fir_delay_line_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIR_DATA_WIDTH,
    parameter int unsigned NUM_REGS   = FIR_NUM_REGS,
    localparam int unsigned CntW      = $clog2(NUM_REGS + 1)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic [DATA_WIDTH-1:0] sampleIn,
    input  logic                  sampleValid,
    output logic                  sampleReady,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] pDataOut [NUM_REGS],
    output logic                  pDataValid,
    input  logic                  pDataReady,
    output logic [CntW-1:0]       fillCount
);

    logic [DATA_WIDTH-1:0] r_taps [NUM_REGS];
    logic [CntW-1:0]       r_fill;
    logic                  r_valid;
    logic                  r_armed;
    fir_state_e            r_state;

    logic                  w_ready;
    logic                  w_accept;
    logic [CntW-1:0]       w_fill_inc;
    logic                  w_full_after;
    logic                  w_valid_next;

    // r_armed stays low through the edge on which rstN deasserts, so that edge
    // can never take a sample even if the source already holds sampleValid.
    assign w_ready      = r_armed && !flush && (!r_valid || pDataReady);
    assign w_accept     = sampleValid && w_ready;
    assign w_fill_inc   = (r_fill == CntW'(NUM_REGS)) ? r_fill : r_fill + 1'b1;
    assign w_full_after = (w_fill_inc == CntW'(NUM_REGS));

    always_comb begin
        w_valid_next = r_valid;
        if (w_accept) begin
`ifdef FIR_ZERO_PAD_EN
            w_valid_next = 1'b1;
`else
            w_valid_next = w_full_after;
`endif
        end else if (pDataReady) begin
            w_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_taps[i] <= '0;
            end
            r_fill  <= '0;
            r_valid <= 1'b0;
            r_armed <= 1'b0;
            r_state <= StFill;
        end else begin
            r_armed <= 1'b1;
            if (flush) begin
                // Drops any pending vector; sampleReady is low so no accept races this.
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    r_taps[i] <= '0;
                end
                r_fill  <= '0;
                r_valid <= 1'b0;
                r_state <= StFill;
            end else begin
                if (w_accept) begin
                    r_taps[0] <= sampleIn;
                    for (int unsigned i = 1; i < NUM_REGS; i++) begin
                        r_taps[i] <= r_taps[i-1];
                    end
                    r_fill <= w_fill_inc;
                end
                r_valid <= w_valid_next;
                unique case (r_state)
                    StFill: begin
                        if (w_accept && w_full_after) begin
                            r_state <= w_valid_next ? StHold : StRun;
                        end
                    end
                    StRun: begin
                        if (w_accept) begin
                            r_state <= StHold;
                        end
                    end
                    StHold: begin
                        // Consume plus simultaneous accept stays in StHold.
                        if (pDataReady && !w_accept) begin
                            r_state <= StRun;
                        end
                    end
                    default: r_state <= StFill;
                endcase
            end
        end
    end

    assign sampleReady = w_ready;
    assign pDataOut    = r_taps;
    assign pDataValid  = r_valid;
    assign fillCount   = r_fill;

endmodule

// File: tb/tb_fir_delay_line.sv
module tb_fir_delay_line;
    import fir_delay_line_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned NR = 4;
    localparam int unsigned CW = $clog2(NR + 1);
`ifdef FIR_ZERO_PAD_EN
    localparam bit ZeroPad = 1'b1;
`else
    localparam bit ZeroPad = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstN;
    logic [DW-1:0] sampleIn;
    logic          sampleValid;
    logic          sampleReady;
    logic          flush;
    logic [DW-1:0] taps [NR];
    logic          pDataValid;
    logic          pDataReady;
    logic [CW-1:0] fillCount;

    fir_delay_line #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .sampleIn    (sampleIn),
        .sampleValid (sampleValid),
        .sampleReady (sampleReady),
        .flush       (flush),
        .pDataOut    (taps),
        .pDataValid  (pDataValid),
        .pDataReady  (pDataReady),
        .fillCount   (fillCount)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int consumed = 0;

    // Reference model: the accepted-sample history since reset/flush, newest first.
    logic [DW-1:0] m_hist[$];
    int            m_fill;
    bit            m_valid;
    bit            m_armed;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_tap(input int i);
        return (i < m_hist.size()) ? m_hist[i] : '0;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_fill  = 0;
        m_valid = 1'b0;
        m_armed = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".pDataValid"}, 64'(pDataValid), 64'(m_valid));
        chk({tag, ".fillCount"}, 64'(fillCount), 64'(m_fill));
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("%s.tap%0d", tag, i), 64'(taps[i]), 64'(exp_tap(i)));
        end
    endtask

    // Inputs are driven before the call (away from the rising edge); one clock.
    task automatic step(input string tag);
        bit exp_ready;
        bit acc;
        #1;
        exp_ready = m_armed && !flush && (!m_valid || pDataReady);
        chk({tag, ".sampleReady"}, 64'(sampleReady), 64'(exp_ready));
        if (pDataValid && pDataReady) consumed++;
        acc = sampleValid && exp_ready;
        if (flush) begin
            m_hist.delete();
            m_fill  = 0;
            m_valid = 1'b0;
        end else if (acc) begin
            m_hist.push_front(sampleIn);
            if (m_hist.size() > NR) void'(m_hist.pop_back());
            m_fill  = (m_fill < NR) ? m_fill + 1 : NR;
            m_valid = ZeroPad ? 1'b1 : (m_fill == NR);
        end else if (pDataReady) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        m_armed = 1'b1;
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit rdy, input bit fl);
        sampleValid = v;
        sampleIn    = d;
        pDataReady  = rdy;
        flush       = fl;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstN = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        chk("reset.sampleReady", 64'(sampleReady), 64'(0));
        rstN = 1'b1;

        // Release edge must not take a sample even with sampleValid high.
        drive(1'b1, 16'hbeef, 1'b1, 1'b0);
        step("release");

        // Warm-up: 1,2,3,4 then 5.
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 16'(k), 1'b1, 1'b0);
            step($sformatf("warm%0d", k));
        end
        // Idle with pDataReady high consumes the [5,4,3,2] vector.
        drive(1'b0, '0, 1'b1, 1'b0);
        step("idle_consume");

        // Backpressure: vector pending, 9 offered while pDataReady low.
        drive(1'b1, 16'd6, 1'b1, 1'b0);
        step("bp_fill");
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 16'd9, 1'b0, 1'b0);
            step($sformatf("bp_hold%0d", k));
        end
        drive(1'b1, 16'd9, 1'b1, 1'b0);
        step("bp_release");

        // Flush collides with a valid sample 7.
        drive(1'b1, 16'd7, 1'b0, 1'b1);
        step("flush");
        // pDataReady with nothing pending is harmless.
        drive(1'b0, '0, 1'b1, 1'b0);
        step("idle_empty");

        // Three samples, then an asynchronous reset between edges.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'(16'h100 + k), 1'b1, 1'b0);
            step($sformatf("pre_rst%0d", k));
        end
        #2 rstN = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        rstN = 1'b1;
        drive(1'b1, 16'h0bad, 1'b1, 1'b0);
        step("rst_release");
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 16'(16'h200 + k), 1'b1, 1'b0);
            step($sformatf("rewarm%0d", k));
        end

        // Fresh start, then 10 and 20 (zero-pad visible when enabled).
        drive(1'b0, '0, 1'b0, 1'b1);
        step("flush2");
        drive(1'b1, 16'd10, 1'b1, 1'b0);
        step("zp10");
        drive(1'b1, 16'd20, 1'b1, 1'b0);
        step("zp20");

        // Streaming: 100 random samples, consumer always ready.
        drive(1'b0, '0, 1'b0, 1'b1);
        step("flush3");
        consumed = 0;
        for (int k = 0; k < 100; k++) begin
            drive(1'b1, 16'($urandom_range(0, 65535)), 1'b1, 1'b0);
            step($sformatf("stream%0d", k));
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step("stream_drain");
        chk("stream.vectors", 64'(consumed), ZeroPad ? 64'(100) : 64'(100 - NR + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_delay_line.md
# fir_delay_line

Sample delay line for the FIR accelerator. Accepts one raw sensor sample per handshake, shifts it into a NUM_REGS-deep tap register chain, and presents all taps in parallel to the multiply-accumulate stage. It tracks warm-up fill and applies valid/ready backpressure so that each new tap vector is consumed exactly once.

## Interface
Parameters:
- DATA_WIDTH, from constants.vh: sample and tap width in bits.
- NUM_REGS, from constants.vh: number of taps; must be ≥2.

Ports:
- clk  in  1  sole clock; all logic rising-edge.
- rstN  in  1  asynchronous active-low reset.
- sampleIn  in  DATA_WIDTH  raw sensor sample.
- sampleValid  in  1  sampleIn is valid.
- sampleReady  out  1  block can accept a sample this cycle.
- flush  in  1  synchronous clear of the delay line.
- pDataOut  out  array [0:NUM_REGS-1] of DATA_WIDTH  parallel taps; index 0 is newest.
- pDataValid  out  1  pDataOut holds an unconsumed tap vector.
- pDataReady  in  1  MAC stage consumes pDataOut this cycle.
- fillCount  out  $clog2(NUM_REGS+1)  samples held, saturating at NUM_REGS.

## Operation
- Accept is sampleValid && sampleReady.
- sampleReady = !flush && (!pDataValid || pDataReady). The register slice passes data through with no skid buffer.
- On accept: pDataOut[0] <= sampleIn; pDataOut[i] <= pDataOut[i-1] for i≥1; the oldest sample is discarded.
- fillCount increments on accept and saturates at NUM_REGS.
- States:
  - FILL: fillCount < NUM_REGS.
  - RUN: full, pDataValid low.
  - HOLD: full, pDataValid high, waiting for pDataReady.
- Transitions:
  - FILL→RUN/HOLD on the accept that makes fillCount reach NUM_REGS.
  - RUN→HOLD on accept.
  - HOLD→RUN on pDataReady with no accept.
  - HOLD→HOLD on pDataReady with a simultaneous accept, which gives back-to-back vectors.
- pDataValid rises the cycle after an accept that leaves fillCount == NUM_REGS. It stays high until pDataReady. Taps are stable while pDataValid && !pDataReady.
- flush: taps, fillCount and pDataValid all clear to 0 next cycle. State returns to FILL. flush beats a simultaneous accept; the sample is not taken because sampleReady is low. An unconsumed vector is dropped.
- No arithmetic is done on samples; widths pass through unchanged.

## Timing
- Reset (rstN low, asynchronous): pDataOut all zero, pDataValid 0, fillCount 0, state FILL.
- sampleReady is combinational from pDataValid, pDataReady and flush. After reset it is high whenever flush is low.
- Latency is 1 cycle from an accepting edge to new pDataOut and pDataValid.
- Throughput is 1 sample per cycle when pDataReady is held high.
- When rstN deasserts mid-stream, no sample is accepted on the deassertion edge. The first accept can occur on the following edge.
- pDataReady while pDataValid is low has no effect.

## Configuration
- FIR_ZERO_PAD_EN defined:
  - Taps start at zero.
  - pDataValid rises after every accept, including during FILL. The first output after reset is [s0,0,0,…].
  - fillCount still counts but does not gate validity.
- FIR_ZERO_PAD_EN undefined:
  - No vector is issued until NUM_REGS samples have been accepted since reset or flush.
  - The first vector is [s(N-1),…,s0].

## Structure
- DATA_WIDTH, NUM_REGS and the state encoding (FILL, RUN, HOLD as localparams) belong in constants.vh, shared with the MAC stage.
- No sub-module: a single module containing the tap chain, fill counter and handshake FSM is natural.

## Test plan
All scenarios use NUM_REGS=4, DATA_WIDTH=16.

- Warm-up, macro off: feed 1,2,3,4 with pDataReady=1 → pDataValid first high one cycle after accepting 4, with pDataOut=[4,3,2,1] and fillCount=4. Feeding 5 → [5,4,3,2].
- Backpressure: full, pDataReady=0, sampleValid=1 with 9 → sampleReady=0 and taps frozen for 5 cycles. Raising pDataReady → 9 accepted on the same edge, next vector has 9 at index 0.
- Flush collision: full, assert flush with sampleValid=1, sample 7 → next cycle taps all 0, fillCount=0, pDataValid=0, 7 not stored.
- Async reset mid-stream: rstN low between clock edges after 3 samples → outputs clear immediately without a clock edge. After release, warm-up needs 4 fresh samples.
- Zero-pad, macro on: feed 10 → pDataValid high next cycle with [10,0,0,0]. Feed 20 → [20,10,0,0].
- Streaming: 100 random samples with pDataValid && pDataReady every cycle → one vector per cycle, each equal to the last 4 inputs newest-first, none dropped or duplicated.
